// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_ctrl_pkg
//  Description : Shared types and constants for the RV32I multicycle
//                controller: state enumeration, supported opcodes, ALU
//                operation encodings and the bundled control-output struct.
//  Revision    : 1.0  initial release
// ============================================================================
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_I    = 4'd2,
        S_WB_ALU    = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_MEM_READ  = 4'd5,
        S_WB_MEM    = 4'd6,
        S_MEM_WRITE = 4'd7,
        S_BRANCH    = 4'd8,
        S_TRAP      = 4'd9
    } mc_state_t;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_BNE  = 7'b1100011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_LW   = 7'b0000011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // Control outputs as produced by the state decoder (illegal is held
    // separately as a sticky register in the top level).
    typedef struct packed {
        logic       mem_req;
        logic       AdrSrc;
        logic       MemWrite;
        logic       IRWrite;
        logic       PCWrite;
        logic       PCsrc;
        logic       ImmSrc;
        logic       ALUsrc;
        logic [2:0] ALUctrl;
        logic       RegWrite;
        logic       ResultSrc;
        logic       retire;
    } mc_ctrl_t;

    // State that follows DECODE for a given opcode.
    function automatic mc_state_t decode_next(input logic [6:0] op);
        mc_state_t nxt;
        case (op)
            OP_ADDI:      nxt = S_EXEC_I;
            OP_LW, OP_SW: nxt = S_MEM_ADDR;
            OP_BNE:       nxt = S_BRANCH;
            default:      nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Bundle between the multicycle controller and the datapath /
//                unified memory.
//                master : controller (drives control outputs)
//                slave  : datapath + memory (drives instr, EQ, mem_ready)
//  Ports       : instr[address_width], EQ, mem_ready      (datapath -> ctrl)
//                mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, PCsrc, ImmSrc,
//                ALUsrc, ALUctrl[3], RegWrite, ResultSrc, retire, illegal
//                                                         (ctrl -> datapath)
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_if #(
    parameter int address_width = 7
);
    logic [address_width-1:0] instr;
    logic                     EQ;
    logic                     mem_ready;

    logic                     mem_req;
    logic                     AdrSrc;
    logic                     MemWrite;
    logic                     IRWrite;
    logic                     PCWrite;
    logic                     PCsrc;
    logic                     ImmSrc;
    logic                     ALUsrc;
    logic [2:0]               ALUctrl;
    logic                     RegWrite;
    logic                     ResultSrc;
    logic                     retire;
    logic                     illegal;

    modport master (
        input  instr, EQ, mem_ready,
        output mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, PCsrc, ImmSrc,
               ALUsrc, ALUctrl, RegWrite, ResultSrc, retire, illegal
    );

    modport slave (
        output instr, EQ, mem_ready,
        input  mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, PCsrc, ImmSrc,
               ALUsrc, ALUctrl, RegWrite, ResultSrc, retire, illegal
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_output_decode
//  Description : Combinational mapping from controller state (plus the
//                memory handshake in the memory states) to control outputs.
//  Ports       : state_i     - current controller state
//                mem_ready_i - memory completes the pending access
//                is_lw_i     - current instruction is a load
//                eq_i        - ALU equal flag (used only in BRANCH)
//                ctrl_o      - control output bundle
//  Revision    : 1.0  initial release
// ============================================================================
module mc_output_decode
    import rv_ctrl_pkg::*;
(
    input  mc_state_t state_i,
    input  logic      mem_ready_i,
    input  logic      is_lw_i,
    input  logic      eq_i,
    output mc_ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req = 1'b1;
                // Latch the instruction and advance PC only on completion.
                if (mem_ready_i) begin
                    ctrl_o.IRWrite = 1'b1;
                    ctrl_o.PCWrite = 1'b1;
                end
            end
            S_EXEC_I: begin
                ctrl_o.ALUsrc  = 1'b1;
                ctrl_o.ImmSrc  = 1'b1;
                ctrl_o.ALUctrl = ALU_ADD;
            end
            S_WB_ALU: begin
                ctrl_o.RegWrite = 1'b1;
                ctrl_o.retire   = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl_o.ALUsrc  = 1'b1;
                ctrl_o.ALUctrl = ALU_ADD;
                // I-type immediate for loads, S-type for stores.
                ctrl_o.ImmSrc  = is_lw_i;
            end
            S_MEM_READ: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.AdrSrc  = 1'b1;
            end
            S_WB_MEM: begin
                ctrl_o.RegWrite  = 1'b1;
                ctrl_o.ResultSrc = 1'b1;
                ctrl_o.retire    = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_req  = 1'b1;
                ctrl_o.AdrSrc   = 1'b1;
                ctrl_o.MemWrite = 1'b1;
                ctrl_o.retire   = mem_ready_i;
            end
            S_BRANCH: begin
                ctrl_o.ALUctrl = ALU_SUB;
                ctrl_o.PCsrc   = 1'b1;
                ctrl_o.PCWrite = ~eq_i;
                ctrl_o.retire  = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multicycle RV32I controller for addi/bne/sw/lw sharing one
//                memory port and one ALU. Holds the state register, the
//                next-state logic and the sticky illegal-opcode flag.
//  Ports       : clk - system clock
//                rst - synchronous active-high reset
//                bus - multicycle_control_if master modport
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int address_width = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    mc_state_t  state_q;
    mc_state_t  state_d;
    logic       illegal_q;
    logic       illegal_d;
    logic [6:0] w_opcode;
    logic       w_is_lw;
    mc_ctrl_t   w_ctrl_raw;
    mc_ctrl_t   w_ctrl;

    assign w_opcode = bus.instr[6:0];
    assign w_is_lw  = (w_opcode == OP_LW);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE:    state_d = decode_next(w_opcode);
            S_EXEC_I:    state_d = S_WB_ALU;
            S_WB_ALU:    state_d = S_FETCH;
            S_MEM_ADDR:  state_d = w_is_lw ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (bus.mem_ready) state_d = S_WB_MEM;
            S_WB_MEM:    state_d = S_FETCH;
            S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;
        endcase
    end

    // Set on entry into TRAP; since TRAP only exits through reset the flag
    // stays high until then.
    assign illegal_d = illegal_q | (state_d == S_TRAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    mc_output_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .is_lw_i     (w_is_lw),
        .eq_i        (bus.EQ),
        .ctrl_o      (w_ctrl_raw)
    );

    // All outputs are suppressed while reset is asserted, whatever the
    // state register currently holds.
    assign w_ctrl = rst ? '0 : w_ctrl_raw;

    assign bus.mem_req   = w_ctrl.mem_req;
    assign bus.AdrSrc    = w_ctrl.AdrSrc;
    assign bus.MemWrite  = w_ctrl.MemWrite;
    assign bus.IRWrite   = w_ctrl.IRWrite;
    assign bus.PCWrite   = w_ctrl.PCWrite;
    assign bus.PCsrc     = w_ctrl.PCsrc;
    assign bus.ImmSrc    = w_ctrl.ImmSrc;
    assign bus.ALUsrc    = w_ctrl.ALUsrc;
    assign bus.ALUctrl   = w_ctrl.ALUctrl;
    assign bus.RegWrite  = w_ctrl.RegWrite;
    assign bus.ResultSrc = w_ctrl.ResultSrc;
    assign bus.retire    = w_ctrl.retire;
    assign bus.illegal   = illegal_q & ~rst;

endmodule
`default_nettype wire
